// File: rtl/axi_apb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axi_apb_pkg
// Description : Shared constants for the APB master: completer count, per-
//               completer address windows and the transfer FSM encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package axi_apb_pkg;

    localparam int SLAVE_NUM = 4;

    localparam logic [31:0] A_START_SLAVE0 = 32'h0000_0000;
    localparam logic [31:0] A_END_SLAVE0   = 32'h0000_0FFF;
    localparam logic [31:0] A_START_SLAVE1 = 32'h0000_1000;
    localparam logic [31:0] A_END_SLAVE1   = 32'h0000_1FFF;
    localparam logic [31:0] A_START_SLAVE2 = 32'h0000_2000;
    localparam logic [31:0] A_END_SLAVE2   = 32'h0000_2FFF;
    localparam logic [31:0] A_START_SLAVE3 = 32'h0000_3000;
    localparam logic [31:0] A_END_SLAVE3   = 32'h0000_3FFF;

    localparam logic [3:0][31:0] c_a_start = {A_START_SLAVE3, A_START_SLAVE2,
                                              A_START_SLAVE1, A_START_SLAVE0};
    localparam logic [3:0][31:0] c_a_end   = {A_END_SLAVE3, A_END_SLAVE2,
                                              A_END_SLAVE1, A_END_SLAVE0};

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_setup  = 2'd1;
    localparam logic [1:0] c_st_access = 2'd2;
    localparam logic [1:0] c_st_resp   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = c_st_idle,
        ST_SETUP  = c_st_setup,
        ST_ACCESS = c_st_access,
        ST_RESP   = c_st_resp
    } apb_state_t;

endpackage
`default_nettype wire

// File: rtl/apb_addr_decoder.sv
`default_nettype none
// ============================================================================
// Module      : apb_addr_decoder
// Description : Combinational address decode into a one-hot completer select;
//               misaligned or unmapped addresses report a miss.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_addr_decoder #(
    parameter int SLAVE_NUM = 4
) (
    input  logic [31:0]          i_addr,
    output logic [SLAVE_NUM-1:0] o_sel,
    output logic                 o_miss
);
    import axi_apb_pkg::*;

    logic [SLAVE_NUM-1:0] w_hit;
    logic                 w_aligned;

    assign w_aligned = (i_addr[1:0] == 2'b00);

    // Offset-from-start compare keeps a single unsigned test per window.
    for (genvar gi = 0; gi < SLAVE_NUM; gi++) begin : g_range
        assign w_hit[gi] = ((i_addr - c_a_start[gi]) <= (c_a_end[gi] - c_a_start[gi]));
    end

    assign o_sel  = w_aligned ? w_hit : '0;
    assign o_miss = ~|o_sel;

endmodule
`default_nettype wire

// File: rtl/apb_master.sv
`default_nettype none
// ============================================================================
// Module      : apb_master
// Description : Single-outstanding command/response to APB bridge with
//               address decode, wait-state timeout and registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_master #(
    parameter int SLAVE_NUM = 4,
    parameter int TIMEOUT   = 16
) (
    input  logic                      pclk,
    input  logic                      preset_n,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic [31:0]               cmd_addr,
    input  logic                      cmd_write,
    input  logic [31:0]               cmd_wdata,
    input  logic [3:0]                cmd_strb,
    input  logic [2:0]                cmd_prot,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [31:0]               rsp_rdata,
    output logic                      rsp_slverr,
    output logic [SLAVE_NUM-1:0]      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [31:0]               paddr,
    output logic [31:0]               pwdata,
    output logic [3:0]                pstrb,
    output logic [2:0]                pprot,
    input  logic [SLAVE_NUM-1:0]      pready,
    input  logic [SLAVE_NUM-1:0]      pslverr,
    input  logic [32*SLAVE_NUM-1:0]   prdata
);
    import axi_apb_pkg::*;

    localparam int c_cnt_w = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    apb_state_t           r_state;
    apb_state_t           w_state_nxt;
    logic                 r_cmd_ready;
    logic [SLAVE_NUM-1:0] r_psel;
    logic                 r_penable;
    logic                 r_pwrite;
    logic [31:0]          r_paddr;
    logic [31:0]          r_pwdata;
    logic [3:0]           r_pstrb;
    logic [2:0]           r_pprot;
    logic                 r_rsp_valid;
    logic [31:0]          r_rsp_rdata;
    logic                 r_rsp_slverr;
    logic [c_cnt_w-1:0]   r_wait_cnt;

    logic [SLAVE_NUM-1:0] w_dec_sel;
    logic                 w_dec_miss;
    logic                 w_accept;
    logic                 w_sel_ready;
    logic                 w_sel_err;
    logic [31:0]          w_sel_rdata;
    logic                 w_timeout;

    apb_addr_decoder #(
        .SLAVE_NUM (SLAVE_NUM)
    ) u_decoder (
        .i_addr (cmd_addr),
        .o_sel  (w_dec_sel),
        .o_miss (w_dec_miss)
    );

    // cmd_ready is low in the first cycle out of reset, so acceptance keys off it.
    assign w_accept    = cmd_valid && r_cmd_ready;
    assign w_sel_ready = |(pready & r_psel);
    assign w_sel_err   = |(pslverr & r_psel);
    assign w_timeout   = (r_wait_cnt == c_cnt_w'(TIMEOUT - 1));

    always_comb begin
        w_sel_rdata = '0;
        for (int i = 0; i < SLAVE_NUM; i++) begin
            if (r_psel[i]) begin
                w_sel_rdata = w_sel_rdata | prdata[32*i +: 32];
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_nxt = w_dec_miss ? ST_RESP : ST_SETUP;
            ST_SETUP:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: if (w_sel_ready || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP:   if (rsp_ready) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            r_cmd_ready  <= 1'b0;
            r_psel       <= '0;
            r_penable    <= 1'b0;
            r_pwrite     <= 1'b0;
            r_paddr      <= '0;
            r_pwdata     <= '0;
            r_pstrb      <= '0;
            r_pprot      <= '0;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_slverr <= 1'b0;
            r_wait_cnt   <= '0;
        end else begin
            r_cmd_ready <= (w_state_nxt == ST_IDLE);
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_wait_cnt <= '0;
                        if (w_dec_miss) begin
                            r_rsp_valid  <= 1'b1;
                            r_rsp_slverr <= 1'b1;
                            r_rsp_rdata  <= '0;
                        end else begin
                            // Reads drive zero write data/strobes onto the bus.
                            r_psel   <= w_dec_sel;
                            r_paddr  <= cmd_addr;
                            r_pwrite <= cmd_write;
                            r_pprot  <= cmd_prot;
                            r_pwdata <= cmd_write ? cmd_wdata : '0;
                            r_pstrb  <= cmd_write ? cmd_strb : '0;
                        end
                    end
                end
                ST_SETUP: begin
                    r_penable <= 1'b1;
                end
                ST_ACCESS: begin
                    if (w_sel_ready) begin
                        r_psel       <= '0;
                        r_penable    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= w_sel_err;
                        r_rsp_rdata  <= (r_pwrite || w_sel_err) ? '0 : w_sel_rdata;
                    end else if (w_timeout) begin
                        r_psel       <= '0;
                        r_penable    <= 1'b0;
                        r_rsp_valid  <= 1'b1;
                        r_rsp_slverr <= 1'b1;
                        r_rsp_rdata  <= '0;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid  <= 1'b0;
                        r_rsp_slverr <= 1'b0;
                        r_rsp_rdata  <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign cmd_ready  = r_cmd_ready;
    assign psel       = r_psel;
    assign penable    = r_penable;
    assign pwrite     = r_pwrite;
    assign paddr      = r_paddr;
    assign pwdata     = r_pwdata;
    assign pstrb      = r_pstrb;
    assign pprot      = r_pprot;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_rdata  = r_rsp_rdata;
    assign rsp_slverr = r_rsp_slverr;

endmodule
`default_nettype wire

// File: tb/tb_apb_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_master
// Description : Scoreboard bench for apb_master with a behavioural completer
//               model, directed corner cases and randomized transfers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_master;

    localparam int SLAVE_NUM = 2;
    localparam int TIMEOUT   = 16;

    logic                    pclk = 1'b0;
    logic                    preset_n = 1'b0;
    logic                    cmd_valid = 1'b0;
    logic                    cmd_ready;
    logic [31:0]             cmd_addr = '0;
    logic                    cmd_write = 1'b0;
    logic [31:0]             cmd_wdata = '0;
    logic [3:0]              cmd_strb = '0;
    logic [2:0]              cmd_prot = '0;
    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [31:0]             rsp_rdata;
    logic                    rsp_slverr;
    logic [SLAVE_NUM-1:0]    psel;
    logic                    penable;
    logic                    pwrite;
    logic [31:0]             paddr;
    logic [31:0]             pwdata;
    logic [3:0]              pstrb;
    logic [2:0]              pprot;
    logic [SLAVE_NUM-1:0]    pready;
    logic [SLAVE_NUM-1:0]    pslverr;
    logic [32*SLAVE_NUM-1:0] prdata;

    apb_master #(
        .SLAVE_NUM (SLAVE_NUM),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .pclk       (pclk),
        .preset_n   (preset_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_addr   (cmd_addr),
        .cmd_write  (cmd_write),
        .cmd_wdata  (cmd_wdata),
        .cmd_strb   (cmd_strb),
        .cmd_prot   (cmd_prot),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_rdata  (rsp_rdata),
        .rsp_slverr (rsp_slverr),
        .psel       (psel),
        .penable    (penable),
        .pwrite     (pwrite),
        .paddr      (paddr),
        .pwdata     (pwdata),
        .pstrb      (pstrb),
        .pprot      (pprot),
        .pready     (pready),
        .pslverr    (pslverr),
        .prdata     (prdata)
    );

    typedef struct {
        int          slave;
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [2:0]  prot;
        logic [31:0] rdata;
        logic        slverr;
        int          lat;
        int          acc;
        int          acc_cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        cur;
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    int          cfg_wait = 0;
    logic        cfg_err = 1'b0;
    logic        cfg_hang = 1'b0;
    logic [31:0] cfg_rdata = '0;
    int          stall_left = 0;
    bit          rand_rr = 1'b0;
    int          acc_k = 0;
    int          last_acc = 0;

    initial forever #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Completer index from the 4 KB window map; -1 for misaligned or unmapped.
    function automatic int ref_slave(input logic [31:0] a);
        logic [31:0] page;
        if (a[1:0] != 2'b00) return -1;
        page = a / 32'h1000;
        if (page < 32'(SLAVE_NUM)) return int'(page);
        return -1;
    endfunction

    // Completer model: drives the selected completer per configured behaviour,
    // drives junk on the others, and checks the bus protocol.
    logic [39:0] snap_a;
    logic [33:0] snap_b;
    initial begin
        logic [SLAVE_NUM-1:0] ep;
        pready = '0; pslverr = '0; prdata = '0;
        forever begin
            @(posedge pclk); #1;
            if (penable && psel != '0) acc_k++; else acc_k = 0;
            if (acc_k > 0) last_acc = acc_k;
            for (int i = 0; i < SLAVE_NUM; i++) begin
                if (i == cur.slave && psel[i] && penable) begin
                    pready[i]          = !cfg_hang && (acc_k > cfg_wait);
                    pslverr[i]         = cfg_err;
                    prdata[32*i +: 32] = cfg_rdata;
                end else begin
                    pready[i]          = 1'($urandom_range(0, 1));
                    pslverr[i]         = ~cfg_err;
                    prdata[32*i +: 32] = $urandom;
                end
            end
            if (preset_n && psel != '0 && !penable) begin
                ep = '0;
                if (cur.slave >= 0) ep[cur.slave] = 1'b1;
                chk("setup_psel",   psel,   ep);
                chk("setup_paddr",  paddr,  cur.addr);
                chk("setup_pwrite", pwrite, cur.write);
                chk("setup_pwdata", pwdata, cur.write ? cur.wdata : 32'h0);
                chk("setup_pstrb",  pstrb,  cur.write ? cur.strb : 4'h0);
                chk("setup_pprot",  pprot,  cur.prot);
                snap_a = {pwrite, pprot, pstrb, paddr};
                snap_b = {psel, pwdata};
            end else if (preset_n && psel != '0 && penable) begin
                chk("access_ctrl_stable", {pwrite, pprot, pstrb, paddr}, snap_a);
                chk("access_data_stable", {psel, pwdata}, snap_b);
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge pclk); #1;
            if (rsp_valid && stall_left > 0) begin
                rsp_ready = 1'b0;
                stall_left--;
            end else if (rsp_valid) begin
                rsp_ready = rand_rr ? ($urandom_range(0, 2) != 0) : 1'b1;
            end else begin
                rsp_ready = rand_rr ? 1'($urandom_range(0, 1)) : 1'b0;
            end
        end
    end

    // Monitor: pops the expected response on the first rsp_valid cycle and
    // checks it on every cycle until the handshake.
    initial begin
        bit   holding;
        exp_t e;
        holding = 1'b0;
        forever begin
            @(negedge pclk);
            if (!preset_n) begin
                holding = 1'b0;
            end else if (rsp_valid) begin
                if (!holding) begin
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_rsp: got rsp_valid=1 expected no response (cycle %0d)", cyc);
                    end else begin
                        e = sb.pop_front();
                        holding = 1'b1;
                        chk("rsp_latency", cyc - e.acc_cyc, e.lat);
                        chk("rsp_bus_idle", {penable, psel}, '0);
                        if (e.slave >= 0) chk("access_cycles", last_acc, e.acc);
                    end
                end
                if (holding) begin
                    chk("rsp_rdata",      rsp_rdata,  e.rdata);
                    chk("rsp_slverr",     rsp_slverr, e.slverr);
                    chk("cmd_ready_busy", cmd_ready,  1'b0);
                end
                if (rsp_ready) holding = 1'b0;
            end else begin
                holding = 1'b0;
            end
        end
    end

    // Called and returns at posedge+1; the command is held until accepted.
    task automatic issue(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                         input logic [3:0] st, input logic [2:0] pr, input int wt,
                         input logic er, input logic hg, input logic [31:0] rd, input int stall);
        exp_t e;
        int   n;
        cmd_addr = addr; cmd_write = wr; cmd_wdata = wd; cmd_strb = st; cmd_prot = pr;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 300) begin
            @(posedge pclk); #1;
            n++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_accept: got cmd_ready=0 expected 1 within 300 cycles (addr 0x%0h)", addr);
            cmd_valid = 1'b0;
            return;
        end
        e.slave = ref_slave(addr);
        e.addr = addr; e.write = wr; e.wdata = wd; e.strb = st; e.prot = pr;
        e.acc_cyc = cyc;
        if (e.slave < 0) begin
            e.slverr = 1'b1; e.rdata = '0; e.lat = 1; e.acc = 0;
        end else if (hg) begin
            e.slverr = 1'b1; e.rdata = '0; e.lat = 2 + TIMEOUT; e.acc = TIMEOUT;
        end else begin
            e.slverr = er;
            e.rdata  = (wr || er) ? 32'h0 : rd;
            e.lat    = 3 + wt;
            e.acc    = wt + 1;
        end
        cfg_wait = wt; cfg_err = er; cfg_hang = hg; cfg_rdata = rd;
        stall_left = stall;
        last_acc = 0;
        cur = e;
        sb.push_back(e);
        @(posedge pclk); #1;
        cmd_valid = 1'b0;
        cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = 1'($urandom_range(0, 1));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rsp_valid) && n < 500) begin
            @(posedge pclk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got no completion expected finish within 30000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] a;
        int          kind;
        cur.slave = -1;
        preset_n = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_apb_ctrl",  {psel, penable, pwrite}, '0);
        chk("rst_paddr",     paddr, '0);
        chk("rst_pwdata",    pwdata, '0);
        chk("rst_pstrb_prot", {pstrb, pprot}, '0);
        chk("rst_rsp",       {rsp_valid, rsp_slverr}, '0);
        chk("rst_rdata",     rsp_rdata, '0);
        chk("rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge pclk); #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        chk("cmd_ready_first_idle", cmd_ready, 1'b1);

        // Zero-wait read of slave1.
        issue(32'h0000_1004, 1'b0, 32'hA5A5_A5A5, 4'hC, 3'b010, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, 0);
        // Write to slave0 with three wait states.
        issue(32'h0000_0008, 1'b1, 32'h1234_5678, 4'hF, 3'b001, 3, 1'b0, 1'b0, 32'h5555_AAAA, 0);
        // Unmapped and misaligned addresses.
        issue(32'h0000_3000, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b0, 32'h1111_2222, 0);
        issue(32'h0000_0002, 1'b1, 32'hCAFE_F00D, 4'h3, 3'b100, 0, 1'b0, 1'b0, 32'h0, 0);
        // Slave0 never ready: timeout.
        issue(32'h0000_0100, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b1, 32'h7777_7777, 0);
        // Slave1 error completion with a stalled response.
        issue(32'h0000_1010, 1'b0, 32'h0, 4'h0, 3'b011, 1, 1'b1, 1'b0, 32'h3333_4444, 5);
        drain();

        // Reset in the middle of an access phase.
        issue(32'h0000_1100, 1'b0, 32'h0, 4'h0, 3'b000, 0, 1'b0, 1'b1, 32'h0, 0);
        repeat (3) begin @(posedge pclk); #1; end
        chk("pre_reset_penable", penable, 1'b1);
        preset_n = 1'b0;
        #1;
        chk("reset_psel",      psel, '0);
        chk("reset_penable",   penable, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_cmd_ready", cmd_ready, 1'b0);
        sb.delete();
        stall_left = 0;
        repeat (2) @(posedge pclk);
        #1;
        preset_n = 1'b1;
        @(posedge pclk); #1;
        chk("cmd_ready_after_reset", cmd_ready, 1'b1);
        issue(32'h0000_0FFC, 1'b0, 32'h0, 4'h0, 3'b101, 2, 1'b0, 1'b0, 32'h0BAD_C0DE, 1);
        drain();

        rand_rr = 1'b1;
        for (int t = 0; t < 40; t++) begin
            kind = int'($urandom_range(0, 9));
            a = $urandom & 32'h0000_0FFC;
            if (kind == 0) begin
                a = a + (($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h0);
                a[1:0] = 2'($urandom_range(1, 3));
            end else if (kind == 1) begin
                a = $urandom;
                a[1:0] = 2'b00;
                if (a < 32'h2000) a = a + 32'h2000;
            end else begin
                a = a + (($urandom_range(0, 1) != 0) ? 32'h1000 : 32'h0);
            end
            issue(a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 4)),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0),
                  $urandom, int'($urandom_range(0, 3)));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
